// File: rtl/logo_bounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logo_bounce_pkg
// Description : Shared types, direction encoding and per-sprite reset values
//               for the multi-sprite logo bounce engine.
// Revision    : 1.0 - initial release
// ============================================================================
package logo_bounce_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  dir;    // {dir_y, dir_x}
        logic [31:0] color;
    } sprite_init_t;

    // Sprites start staggered diagonally; odd sprites head left so they diverge.
    function automatic sprite_init_t sprite_init(input int idx, input int spr_w,
                                                 input int spr_h, input int color_w);
        sprite_init_t s;
        s.x     = 32'(idx * spr_w);
        s.y     = 32'(idx * spr_h / 2);
        s.dir   = {DIR_INC, ~idx[0]};
        s.color = 32'(idx % (1 << color_w));
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// ============================================================================
// Module      : bounce_axis
// Description : Combinational single-axis position step with edge reflection.
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_axis
    import logo_bounce_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int SPEED_W = 3
) (
    input  logic [COORD_W-1:0] i_p,
    input  logic               i_dir,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [COORD_W-1:0] i_max,
    output logic [COORD_W-1:0] o_p_next,
    output logic               o_dir_next,
    output logic               o_hit
);

    logic [COORD_W:0] w_p_ext;
    logic [COORD_W:0] w_spd_ext;
    logic [COORD_W:0] w_max_ext;
    logic [COORD_W:0] w_sum;
    logic [COORD_W:0] w_diff;

    // One extra bit keeps p+speed from wrapping near the top of the range.
    assign w_p_ext   = {1'b0, i_p};
    assign w_spd_ext = (COORD_W+1)'(i_speed);
    assign w_max_ext = {1'b0, i_max};
    assign w_sum     = w_p_ext + w_spd_ext;
    assign w_diff    = w_p_ext - w_spd_ext;

    always_comb begin
        o_p_next   = i_p;
        o_dir_next = i_dir;
        o_hit      = 1'b0;
        // Zero speed freezes the sprite, even when parked on an edge.
        if (i_speed != '0) begin
            if (i_dir == DIR_INC) begin
                if (w_sum >= w_max_ext) begin
                    o_p_next   = i_max;
                    o_dir_next = DIR_DEC;
                    o_hit      = 1'b1;
                end else begin
                    o_p_next = w_sum[COORD_W-1:0];
                end
            end else begin
                if (w_p_ext <= w_spd_ext) begin
                    o_p_next   = '0;
                    o_dir_next = DIR_INC;
                    o_hit      = 1'b1;
                end else begin
                    o_p_next = w_diff[COORD_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/logo_bounce_engine.sv
`default_nettype none
// ============================================================================
// Module      : logo_bounce_engine
// Description : Multi-sprite bounce engine; one sprite per cycle per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module logo_bounce_engine
    import logo_bounce_pkg::*;
#(
    parameter int N_SPRITES = 4,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 64,
    parameter int COORD_W   = 10,
    parameter int SPEED_W   = 3,
    parameter int COLOR_W   = 3,
    localparam int IDX_W    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           frame_tick,
    input  logic [SPEED_W-1:0]             speed,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [IDX_W-1:0]               load_idx,
    input  logic [COORD_W-1:0]             load_x,
    input  logic [COORD_W-1:0]             load_y,
    input  logic [1:0]                     load_dir,
    output logic [N_SPRITES*COORD_W-1:0]   pos_x,
    output logic [N_SPRITES*COORD_W-1:0]   pos_y,
    output logic [N_SPRITES*COLOR_W-1:0]   color_idx,
    output logic [N_SPRITES-1:0]           bounce,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);

    localparam int X_MAX = H_ACTIVE - SPR_W;
    localparam int Y_MAX = V_ACTIVE - SPR_H;

    localparam logic [COORD_W-1:0] c_x_max     = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] c_y_max     = COORD_W'(Y_MAX);
    localparam logic [IDX_W-1:0]   c_last_idx  = IDX_W'(N_SPRITES - 1);
    localparam logic [IDX_W:0]     c_n_sprites = (IDX_W+1)'(N_SPRITES);

    if (N_SPRITES < 1 || N_SPRITES > 8) begin : g_err_count
        $error("logo_bounce_engine: N_SPRITES must be in 1..8");
    end
    if (N_SPRITES*SPR_W > X_MAX || N_SPRITES*SPR_H/2 > Y_MAX) begin : g_err_fit
        $error("logo_bounce_engine: reset layout does not fit the active area");
    end
    if ((1 << COORD_W) < H_ACTIVE || (1 << COORD_W) < V_ACTIVE) begin : g_err_coord
        $error("logo_bounce_engine: COORD_W too narrow for the active area");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_idx;
    logic [SPEED_W-1:0]   r_speed;
    logic [COORD_W-1:0]   r_pos_x [N_SPRITES];
    logic [COORD_W-1:0]   r_pos_y [N_SPRITES];
    logic [1:0]           r_dir   [N_SPRITES];
    logic [COLOR_W-1:0]   r_color [N_SPRITES];
    logic [N_SPRITES-1:0] r_bounce;
    logic                 r_frame_done;
    logic                 r_overrun;

    logic [COORD_W-1:0]   w_rst_x     [N_SPRITES];
    logic [COORD_W-1:0]   w_rst_y     [N_SPRITES];
    logic [1:0]           w_rst_dir   [N_SPRITES];
    logic [COLOR_W-1:0]   w_rst_color [N_SPRITES];

    logic                 w_start;
    logic                 w_commit;
    logic                 w_last;
    logic                 w_load;
    logic [COORD_W-1:0]   w_load_x;
    logic [COORD_W-1:0]   w_load_y;
    logic [COORD_W-1:0]   w_nx;
    logic [COORD_W-1:0]   w_ny;
    logic                 w_ndx;
    logic                 w_ndy;
    logic                 w_hit_x;
    logic                 w_hit_y;
    logic                 w_hit;

    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_sprite
        localparam sprite_init_t c_init = sprite_init(gi, SPR_W, SPR_H, COLOR_W);
        assign w_rst_x[gi]     = c_init.x[COORD_W-1:0];
        assign w_rst_y[gi]     = c_init.y[COORD_W-1:0];
        assign w_rst_dir[gi]   = c_init.dir;
        assign w_rst_color[gi] = c_init.color[COLOR_W-1:0];

        assign pos_x[gi*COORD_W +: COORD_W]     = r_pos_x[gi];
        assign pos_y[gi*COORD_W +: COORD_W]     = r_pos_y[gi];
        assign color_idx[gi*COLOR_W +: COLOR_W] = r_color[gi];
    end

    assign bounce     = r_bounce;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        load_ready   = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (enable && frame_tick) begin
                    w_start      = 1'b1;
                    w_state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                busy     = 1'b1;
                w_commit = 1'b1;
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_last   = (r_idx == c_last_idx);
    assign w_load   = load_valid && load_ready && ({1'b0, load_idx} < c_n_sprites);
    assign w_load_x = (load_x > c_x_max) ? c_x_max : load_x;
    assign w_load_y = (load_y > c_y_max) ? c_y_max : load_y;

    bounce_axis #(
        .COORD_W (COORD_W),
        .SPEED_W (SPEED_W)
    ) u_axis_x (
        .i_p        (r_pos_x[r_idx]),
        .i_dir      (r_dir[r_idx][0]),
        .i_speed    (r_speed),
        .i_max      (c_x_max),
        .o_p_next   (w_nx),
        .o_dir_next (w_ndx),
        .o_hit      (w_hit_x)
    );

    bounce_axis #(
        .COORD_W (COORD_W),
        .SPEED_W (SPEED_W)
    ) u_axis_y (
        .i_p        (r_pos_y[r_idx]),
        .i_dir      (r_dir[r_idx][1]),
        .i_speed    (r_speed),
        .i_max      (c_y_max),
        .o_p_next   (w_ny),
        .o_dir_next (w_ndy),
        .o_hit      (w_hit_y)
    );

    // A corner hit still advances the colour by one.
    assign w_hit = w_hit_x | w_hit_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_speed      <= '0;
            r_bounce     <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < N_SPRITES; i++) begin
                r_pos_x[i] <= w_rst_x[i];
                r_pos_y[i] <= w_rst_y[i];
                r_dir[i]   <= w_rst_dir[i];
                r_color[i] <= w_rst_color[i];
            end
        end else begin
            r_bounce     <= '0;
            r_frame_done <= w_commit && w_last;
            if (frame_tick && busy) begin
                r_overrun <= 1'b1;
            end
            if (w_start) begin
                r_speed <= speed;
                r_idx   <= '0;
            end else if (w_commit) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            // Load only happens in IDLE, commit only in UPDATE: never both.
            if (w_load) begin
                r_pos_x[load_idx] <= w_load_x;
                r_pos_y[load_idx] <= w_load_y;
                r_dir[load_idx]   <= load_dir;
            end
            if (w_commit) begin
                r_pos_x[r_idx]  <= w_nx;
                r_pos_y[r_idx]  <= w_ny;
                r_dir[r_idx]    <= {w_ndy, w_ndx};
                r_color[r_idx]  <= r_color[r_idx] + COLOR_W'(w_hit);
                r_bounce[r_idx] <= w_hit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logo_bounce_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_logo_bounce_engine
// Description : Directed self-checking bench for logo_bounce_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logo_bounce_engine;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        frame_tick;
    logic [2:0]  speed;
    logic        load_valid;
    logic        load_ready;
    logic [1:0]  load_idx;
    logic [9:0]  load_x;
    logic [9:0]  load_y;
    logic [1:0]  load_dir;
    logic [39:0] pos_x;
    logic [39:0] pos_y;
    logic [11:0] color_idx;
    logic [3:0]  bounce;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int n_cmp;
    int n_err;
    int busy_cnt;
    int done_cnt;
    int bcnt [4];

    logo_bounce_engine dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frame_tick (frame_tick),
        .speed      (speed),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_x     (load_x),
        .load_y     (load_y),
        .load_dir   (load_dir),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .color_idx  (color_idx),
        .bounce     (bounce),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_spr(input string tag, input int i, input int ex, input int ey, input int ec);
        check_eq($sformatf("%s_x%0d", tag, i), 32'(pos_x[i*10 +: 10]), ex);
        check_eq($sformatf("%s_y%0d", tag, i), 32'(pos_y[i*10 +: 10]), ey);
        check_eq($sformatf("%s_c%0d", tag, i), 32'(color_idx[i*3 +: 3]), ec);
    endtask

    task automatic clr_counts();
        busy_cnt = 0;
        done_cnt = 0;
        for (int s = 0; s < 4; s++) bcnt[s] = 0;
    endtask

    task automatic observe(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            if (busy) busy_cnt++;
            if (frame_done) done_cnt++;
            for (int s = 0; s < 4; s++) if (bounce[s]) bcnt[s]++;
            @(negedge clk);
        end
    endtask

    task automatic do_tick(input int spd);
        @(negedge clk);
        enable     = 1'b1;
        speed      = 3'(spd);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        observe(10);
    endtask

    task automatic do_load(input int idx, input int x, input int y, input int dir);
        @(negedge clk);
        load_valid = 1'b1;
        load_idx   = 2'(idx);
        load_x     = 10'(x);
        load_y     = 10'(y);
        load_dir   = 2'(dir);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        enable     = 1'b0;
        frame_tick = 1'b0;
        speed      = '0;
        load_valid = 1'b0;
        load_idx   = '0;
        load_x     = '0;
        load_y     = '0;
        load_dir   = '0;
        clr_counts();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset layout
        check_spr("rst", 0, 0, 0, 0);
        check_spr("rst", 1, 64, 32, 1);
        check_spr("rst", 2, 128, 64, 2);
        check_spr("rst", 3, 192, 96, 3);
        check_eq("rst_load_ready", 32'(load_ready), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_overrun", 32'(overrun), 0);
        check_eq("rst_bounce", 32'(bounce), 0);

        // One frame at speed 4
        clr_counts();
        do_tick(4);
        check_spr("t1", 0, 4, 4, 0);
        check_spr("t1", 1, 60, 36, 1);
        check_spr("t1", 2, 132, 68, 2);
        check_spr("t1", 3, 188, 100, 3);
        check_eq("t1_busy_cycles", 32'(busy_cnt), 4);
        check_eq("t1_done_pulses", 32'(done_cnt), 1);
        check_eq("t1_bounces", 32'(bcnt[0] + bcnt[1] + bcnt[2] + bcnt[3]), 0);

        // Fifteen more frames: sprite 1 reaches the left edge on frame 16
        clr_counts();
        repeat (15) do_tick(4);
        check_spr("t16", 0, 64, 64, 0);
        check_spr("t16", 1, 0, 96, 2);
        check_spr("t16", 3, 128, 160, 3);
        check_eq("t16_bounce1", 32'(bcnt[1]), 1);
        check_eq("t16_bounce_other", 32'(bcnt[0] + bcnt[2] + bcnt[3]), 0);

        // Corner hit on sprite 2
        do_load(2, 574, 414, 3);
        clr_counts();
        do_tick(2);
        check_spr("corner", 2, 576, 416, 3);
        check_spr("corner", 1, 2, 98, 2);
        check_spr("corner", 0, 66, 66, 0);
        check_spr("corner", 3, 126, 162, 3);
        check_eq("corner_bounce2", 32'(bcnt[2]), 1);
        check_eq("corner_bounce_other", 32'(bcnt[0] + bcnt[1] + bcnt[3]), 0);

        // Second tick two cycles into a sweep
        clr_counts();
        @(negedge clk);
        speed      = 3'd0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        observe(1);
        frame_tick = 1'b1;
        observe(1);
        frame_tick = 1'b0;
        observe(10);
        check_eq("ovr_flag", 32'(overrun), 1);
        check_eq("ovr_busy_cycles", 32'(busy_cnt), 4);
        check_eq("ovr_done_pulses", 32'(done_cnt), 1);

        // Ticks ignored with enable low
        clr_counts();
        @(negedge clk);
        enable     = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        observe(6);
        check_eq("dis_busy_cycles", 32'(busy_cnt), 0);
        check_eq("dis_done_pulses", 32'(done_cnt), 0);
        check_eq("dis_overrun_sticky", 32'(overrun), 1);

        // Clamped load and parking on edges
        do_load(3, 700, 500, 3);
        check_spr("clamp", 3, 576, 416, 3);
        do_load(0, 0, 0, 0);
        clr_counts();
        do_tick(0);
        check_spr("spd0", 0, 0, 0, 0);
        check_spr("spd0", 1, 2, 98, 2);
        check_spr("spd0", 2, 576, 416, 3);
        check_spr("spd0", 3, 576, 416, 3);
        check_eq("spd0_bounces", 32'(bcnt[0] + bcnt[1] + bcnt[2] + bcnt[3]), 0);
        check_eq("spd0_busy_cycles", 32'(busy_cnt), 4);

        // Load and tick in the same cycle
        clr_counts();
        @(negedge clk);
        load_valid = 1'b1;
        load_idx   = 2'd0;
        load_x     = 10'd100;
        load_y     = 10'd100;
        load_dir   = 2'b11;
        enable     = 1'b1;
        speed      = 3'd1;
        frame_tick = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        frame_tick = 1'b0;
        observe(10);
        check_spr("ldtk", 0, 101, 101, 0);
        check_spr("ldtk", 1, 3, 99, 2);
        check_spr("ldtk", 2, 575, 415, 3);
        check_spr("ldtk", 3, 576, 416, 4);
        check_eq("ldtk_bounce3", 32'(bcnt[3]), 1);
        check_eq("ldtk_bounce_other", 32'(bcnt[0] + bcnt[1] + bcnt[2]), 0);

        // Asynchronous reset in the middle of a sweep
        @(negedge clk);
        speed      = 3'd4;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check_eq("mid_busy", 32'(busy), 1);
        check_eq("mid_load_ready", 32'(load_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check_spr("arst", i, i * 64, i * 32, i);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_load_ready", 32'(load_ready), 1);
        check_eq("arst_overrun", 32'(overrun), 0);
        check_eq("arst_bounce", 32'(bounce), 0);
        check_eq("arst_frame_done", 32'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logo_bounce_engine.md
Name: logo_bounce_engine

Overview:
- Parametrised multi-sprite motion engine for the logo screensaver; successor to the single-logo bounce logic.
- Tracks N_SPRITES logos, each with its own position, direction and colour index.
- Once per video frame, it updates every sprite sequentially through one shared axis-step datapath.
- Sits between the VGA timing generator (supplies frame_tick) and the pixel renderer (consumes positions and colours).

Parameters:
N_SPRITES, 4, number of independently bouncing logos (1..8)
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SPR_W, 64, sprite width in pixels
SPR_H, 64, sprite height in pixels
COORD_W, 10, coordinate width; must hold H_ACTIVE-1 and V_ACTIVE-1
SPEED_W, 3, speed field width in pixels per frame
COLOR_W, 3, colour index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  motion enable; when low, frame_tick is ignored
frame_tick  in  1  one-cycle pulse at start of vblank
speed  in  SPEED_W  step size, latched when frame_tick is accepted
load_valid  in  1  request to overwrite one sprite's state
load_ready  out  1  high only in IDLE
load_idx  in  $clog2(N_SPRITES) (min 1)  sprite to overwrite
load_x  in  COORD_W  new x
load_y  in  COORD_W  new y
load_dir  in  2  new {dir_y, dir_x}; 1 = increasing
pos_x  out  N_SPRITES*COORD_W  packed x positions, sprite 0 in LSBs
pos_y  out  N_SPRITES*COORD_W  packed y positions
color_idx  out  N_SPRITES*COLOR_W  packed colour indices
bounce  out  N_SPRITES  one-cycle pulse per sprite on any edge hit
busy  out  1  update sweep in progress
frame_done  out  1  one-cycle pulse when a sweep completes
overrun  out  1  sticky: frame_tick arrived while busy; cleared only by rst

Behaviour:
- Constants: X_MAX = H_ACTIVE-SPR_W; Y_MAX = V_ACTIVE-SPR_H.
- Elaboration check: N_SPRITES*SPR_W <= X_MAX and N_SPRITES*SPR_H/2 <= Y_MAX.
- Reset values, sprite i:
  - pos_x = i*SPR_W; pos_y = i*SPR_H/2.
  - dir_x = ~i[0] (even sprites move right); dir_y = 1.
  - color_idx = i mod 2^COLOR_W.
  - bounce, busy, frame_done, overrun = 0; state IDLE; load_ready = 1.
- FSM states: IDLE, UPDATE.
  - IDLE -> UPDATE when enable & frame_tick. Latch speed; idx = 0.
  - UPDATE: each cycle, commit sprite idx and increment idx.
  - After idx = N_SPRITES-1, return to IDLE and pulse frame_done for one cycle.
- Timing: tick sampled at edge E0.
  - busy is high from E0 through edge E0+N_SPRITES.
  - Sprite i's new values are visible after edge E0+1+i.
  - bounce[i] is high in the cycle after that edge.
- Axis step, moving up (dir=1):
  - If p+speed >= MAX: p = MAX, dir flips, hit.
  - Otherwise p += speed.
  - Compute in COORD_W+1 bits; no wrap is permitted.
- Axis step, moving down (dir=0):
  - If p <= speed: p = 0, dir flips, hit.
  - Otherwise p -= speed.
- speed = 0 (latched): positions hold and no hits, even at p = 0 or p = MAX.
- Bounce: hit_x | hit_y.
  - Sets bounce[i]; color_idx[i] increments by exactly 1, including a corner hit on both axes.
  - color_idx wraps at 2^COLOR_W-1 -> 0.
- Load: accepted when load_valid & load_ready (IDLE only).
  - Coordinates are clamped to X_MAX / Y_MAX. Colour is unchanged; no bounce.
  - If load and frame_tick arrive in the same cycle: load is applied and the sweep starts in that cycle, so the sweep uses the loaded values.
- frame_tick while busy: ignored; overrun set.
- enable low mid-sweep: the sweep completes; later ticks are ignored.
- rst mid-sweep: all state returns to reset values immediately.

Decomposition:
- Package logo_bounce_pkg:
  - FSM state enum.
  - Dir encoding constants (DIR_INC = 1, DIR_DEC = 0).
  - Function computing the reset x/y/dir/colour for index i.
- Sub-module bounce_axis: combinational one-axis step.
  - Inputs: p, dir, speed, max. Outputs: p_next, dir_next, hit.
  - Instantiated twice (x and y) on the shared datapath.

Test Plan:
- Reset release -> sprites at (0,0), (64,32), (128,64), (192,96); colours 0, 1, 2, 3; load_ready = 1; busy = 0.
- speed=4, one tick -> sprites at (4,4), (60,36), (132,68), (188,100); busy high for 4 cycles; frame_done one pulse; no bounce.
- speed=4, 16 ticks -> sprite1 reaches x=0 on tick 16 with dir_x flipped to 1; bounce[1] pulses once; color_idx[1] = 2; y = 96.
- Corner case: load sprite2 to (574,414) with dir=2'b11, speed=2, one tick -> (576,416), dir=2'b00, color_idx 2 -> 3, a single bounce[2] pulse.
- Second frame_tick 2 cycles after the first (N=4) -> tick ignored and overrun stays 1. Further: speed=0 ticks -> no motion; enable=0 -> no busy.
- rst asserted at sweep cycle 2 -> all outputs return to reset values before the next edge. Further: load_idx=3 with load_x=700 -> pos_x[3] = 576.
